// File: rtl/stepper_phase_decoder.sv
// Stepper phase-line decoder: debounce, half-step index tracking, step/direction/position,
// and step period measurement when STEPPER_PERIOD_MEASURE_EN is defined.
module stepper_phase_decoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int POS_WIDTH       = 32,
  parameter int PERIOD_WIDTH    = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              phase_in,
  input  logic                    clear,
  output logic                    step_pulse,
  output logic                    step_dir,
  output logic [POS_WIDTH-1:0]    position,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic                    period_valid,
  output logic                    fault,
  output logic                    fault_flag,
  output logic                    energised
);
  localparam logic [7:0] DEB_MAX = 8'(DEBOUNCE_CYCLES);

  // Returns {legal, half-step index}; 0000 and illegal patterns both report legal=0.
  function automatic logic [3:0] phase_to_index(input logic [3:0] p);
    case (p)
      4'b0001: phase_to_index = 4'b1000;
      4'b0011: phase_to_index = 4'b1001;
      4'b0010: phase_to_index = 4'b1010;
      4'b0110: phase_to_index = 4'b1011;
      4'b0100: phase_to_index = 4'b1100;
      4'b1100: phase_to_index = 4'b1101;
      4'b1000: phase_to_index = 4'b1110;
      4'b1001: phase_to_index = 4'b1111;
      default: phase_to_index = 4'b0000;
    endcase
  endfunction

  logic [3:0]                  cand_q, cand_d, stable_q, stable_d;
  logic [7:0]                  cnt_q, cnt_d;
  logic                        accept_q, accept_d;
  logic [2:0]                  idx_q, idx_d;
  logic                        idx_vld_q, idx_vld_d;
  logic                        step_pulse_q, step_pulse_d, step_dir_q, step_dir_d;
  logic signed [POS_WIDTH-1:0] position_q, position_d;
  logic                        fault_q, fault_d, fault_flag_q, fault_flag_d;
  logic                        energised_q, energised_d;
  logic                        step_evt;
  logic signed [2:0]           step_delta;
  logic [3:0]                  dec;
  logic [2:0]                  diff;

`ifdef STEPPER_PERIOD_MEASURE_EN
  logic [PERIOD_WIDTH-1:0] per_cnt_q, per_cnt_d, period_q, period_d;
  logic                    per_ref_q, per_ref_d, period_vld_q, period_vld_d;

  function automatic logic [PERIOD_WIDTH-1:0] sat_inc(input logic [PERIOD_WIDTH-1:0] v);
    sat_inc = (v == '1) ? v : v + PERIOD_WIDTH'(1);
  endfunction
`endif

  always_comb begin
    cand_d       = cand_q;
    cnt_d        = cnt_q;
    stable_d     = stable_q;
    accept_d     = 1'b0;
    idx_d        = idx_q;
    idx_vld_d    = idx_vld_q;
    step_pulse_d = 1'b0;
    step_dir_d   = step_dir_q;
    position_d   = position_q;
    fault_d      = 1'b0;
    fault_flag_d = fault_flag_q;
    energised_d  = energised_q;
    step_evt     = 1'b0;
    step_delta   = '0;
    dec          = phase_to_index(stable_q);
    diff         = dec[2:0] - idx_q;

    // Stage 1: debounce; a pattern is accepted once it has been seen DEBOUNCE_CYCLES times in a row
    if (phase_in != cand_q) begin
      cand_d = phase_in;
      cnt_d  = 8'd1;
    end else if (cnt_q < DEB_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end
    if (cnt_q == DEB_MAX && cand_q != stable_q) begin
      stable_d = cand_q;
      accept_d = 1'b1;
    end

    // Stage 2: decode the newly accepted pattern into step/fault events
    if (accept_q) begin
      energised_d = (stable_q != 4'b0000);
      if (stable_q == 4'b0000) begin
        energised_d = 1'b0;
      end else if (!dec[3]) begin
        fault_d      = 1'b1;
        fault_flag_d = 1'b1;
      end else if (!idx_vld_q) begin
        idx_d     = dec[2:0];
        idx_vld_d = 1'b1;
      end else begin
        idx_d = dec[2:0];
        case (diff)
          3'd0: ;
          3'd1: begin step_evt = 1'b1; step_delta = 3'sd1;  end
          3'd2: begin step_evt = 1'b1; step_delta = 3'sd2;  end
          3'd7: begin step_evt = 1'b1; step_delta = -3'sd1; end
          3'd6: begin step_evt = 1'b1; step_delta = -3'sd2; end
          default: begin
            fault_d      = 1'b1;
            fault_flag_d = 1'b1;
          end
        endcase
      end
    end

    if (step_evt) begin
      step_pulse_d = 1'b1;
      step_dir_d   = ~step_delta[2];
      position_d   = position_q + POS_WIDTH'(step_delta);
    end

`ifdef STEPPER_PERIOD_MEASURE_EN
    per_cnt_d    = sat_inc(per_cnt_q);
    per_ref_d    = per_ref_q;
    period_d     = period_q;
    period_vld_d = 1'b0;
    if (step_evt) begin
      if (per_ref_q) begin
        period_d     = per_cnt_q;
        period_vld_d = 1'b1;
      end
      per_cnt_d = PERIOD_WIDTH'(1);
      per_ref_d = 1'b1;
    end
`endif

    // clear overrides accumulated state but keeps an index that was just (re)established
    if (clear) begin
      position_d   = '0;
      fault_flag_d = 1'b0;
      if (!(accept_q && dec[3])) idx_vld_d = 1'b0;
`ifdef STEPPER_PERIOD_MEASURE_EN
      per_cnt_d    = '0;
      per_ref_d    = 1'b0;
      period_vld_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand_q       <= 4'b0000;
      cnt_q        <= 8'd0;
      stable_q     <= 4'b0000;
      accept_q     <= 1'b0;
      idx_q        <= 3'd0;
      idx_vld_q    <= 1'b0;
      step_pulse_q <= 1'b0;
      step_dir_q   <= 1'b0;
      position_q   <= '0;
      fault_q      <= 1'b0;
      fault_flag_q <= 1'b0;
      energised_q  <= 1'b0;
`ifdef STEPPER_PERIOD_MEASURE_EN
      per_cnt_q    <= '0;
      per_ref_q    <= 1'b0;
      period_q     <= '0;
      period_vld_q <= 1'b0;
`endif
    end else begin
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      stable_q     <= stable_d;
      accept_q     <= accept_d;
      idx_q        <= idx_d;
      idx_vld_q    <= idx_vld_d;
      step_pulse_q <= step_pulse_d;
      step_dir_q   <= step_dir_d;
      position_q   <= position_d;
      fault_q      <= fault_d;
      fault_flag_q <= fault_flag_d;
      energised_q  <= energised_d;
`ifdef STEPPER_PERIOD_MEASURE_EN
      per_cnt_q    <= per_cnt_d;
      per_ref_q    <= per_ref_d;
      period_q     <= period_d;
      period_vld_q <= period_vld_d;
`endif
    end
  end

  assign step_pulse = step_pulse_q;
  assign step_dir   = step_dir_q;
  assign position   = position_q;
  assign fault      = fault_q;
  assign fault_flag = fault_flag_q;
  assign energised  = energised_q;
`ifdef STEPPER_PERIOD_MEASURE_EN
  assign period       = period_q;
  assign period_valid = period_vld_q;
`else
  assign period       = '0;
  assign period_valid = 1'b0;
`endif

endmodule
